// File: rtl/sn76489_psg_bus_interface.sv
// rtl/sn76489_psg_bus_interface.sv - SN76489 PSG CPU write interface with wait window (optional GG_STEREO_EN stereo register)
module sn76489_psg_bus_interface #(
    parameter int NUM_TONE    = 3,
    parameter int WAIT_CYCLES = 32
) (
    input  logic                    clock,
    input  logic                    nReset,
    input  logic [7:0]              d,
    input  logic                    nWE,
    input  logic                    nCE,
    output logic                    ready,
    output logic [NUM_TONE*10-1:0]  freq,
    output logic [NUM_TONE*4-1:0]   att,
    output logic [3:0]              attNoise,
    output logic                    noiseFeedbackType,
    output logic [1:0]              noiseFeed,
    output logic                    noiseReset
`ifdef GG_STEREO_EN
    ,
    input  logic                    nStereoCE,
    output logic [7:0]              stereo
`endif
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [7:0]               byte_q, byte_d;
    logic [2:0]               latch_q, latch_d;
    logic [NUM_TONE*10-1:0]   freq_q, freq_d;
    logic [NUM_TONE*4-1:0]    att_q, att_d;
    logic [3:0]               att_noise_q, att_noise_d;
    logic                     nfb_q, nfb_d;
    logic [1:0]               nfeed_q, nfeed_d;
    logic                     noise_reset_q, noise_reset_d;
    logic [2:0]               target;
    logic                     bus_released;
`ifdef GG_STEREO_EN
    logic                     stereo_sel_q, stereo_sel_d;
    logic [7:0]               stereo_q, stereo_d;
`endif

    // Next-state: capture on strobe, count the wait window, commit once, then wait for strobe release
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        byte_d        = byte_q;
        latch_d       = latch_q;
        freq_d        = freq_q;
        att_d         = att_q;
        att_noise_d   = att_noise_q;
        nfb_d         = nfb_q;
        nfeed_d       = nfeed_q;
        noise_reset_d = 1'b0;
        target        = latch_q;
        bus_released  = nCE && nWE;
`ifdef GG_STEREO_EN
        stereo_sel_d  = stereo_sel_q;
        stereo_d      = stereo_q;
        bus_released  = nCE && nWE && nStereoCE;
`endif
        case (state_q)
            ST_IDLE: begin
                // PSG chip enable is checked first so it wins over a simultaneous stereo select
                if (!nCE && !nWE) begin
                    byte_d  = d;
                    cnt_d   = CW'(WAIT_CYCLES - 1);
                    state_d = ST_BUSY;
`ifdef GG_STEREO_EN
                    stereo_sel_d = 1'b0;
                end else if (!nStereoCE && !nWE) begin
                    byte_d       = d;
                    cnt_d        = CW'(WAIT_CYCLES - 1);
                    state_d      = ST_BUSY;
                    stereo_sel_d = 1'b1;
`endif
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = ST_FINISH;
`ifdef GG_STEREO_EN
                    if (stereo_sel_q)
                        stereo_d = byte_q;
                    else
`endif
                    begin
                        // A latch byte retargets the register; a data byte reuses the last latch
                        if (byte_q[7]) begin
                            latch_d = byte_q[6:4];
                            target  = byte_q[6:4];
                        end
                        if (target[2:1] == 2'd3) begin
                            if (target[0]) begin
                                att_noise_d = byte_q[3:0];
                            end else begin
                                nfb_d         = byte_q[2];
                                nfeed_d       = byte_q[1:0];
                                noise_reset_d = 1'b1;
                            end
                        end else begin
                            // Channels at or above NUM_TONE match no slot and are silently ignored
                            for (int ch = 0; ch < NUM_TONE; ch++) begin
                                if (int'(target[2:1]) == ch) begin
                                    if (target[0])
                                        att_d[ch*4 +: 4] = byte_q[3:0];
                                    else if (byte_q[7])
                                        freq_d[ch*10 +: 4] = byte_q[3:0];
                                    else
                                        freq_d[ch*10+4 +: 6] = byte_q[5:0];
                                end
                            end
                        end
                    end
                end
            end
            ST_FINISH: begin
                if (bus_released)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and register file; reset restores silence (full attenuation) and tone-0 latch
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            byte_q        <= 8'h00;
            latch_q       <= 3'b000;
            freq_q        <= '0;
            att_q         <= '1;
            att_noise_q   <= 4'hF;
            nfb_q         <= 1'b0;
            nfeed_q       <= 2'b00;
            noise_reset_q <= 1'b0;
`ifdef GG_STEREO_EN
            stereo_sel_q  <= 1'b0;
            stereo_q      <= 8'hFF;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            byte_q        <= byte_d;
            latch_q       <= latch_d;
            freq_q        <= freq_d;
            att_q         <= att_d;
            att_noise_q   <= att_noise_d;
            nfb_q         <= nfb_d;
            nfeed_q       <= nfeed_d;
            noise_reset_q <= noise_reset_d;
`ifdef GG_STEREO_EN
            stereo_sel_q  <= stereo_sel_d;
            stereo_q      <= stereo_d;
`endif
        end
    end

    assign ready             = (state_q == ST_IDLE) || (state_q == ST_FINISH);
    assign freq              = freq_q;
    assign att               = att_q;
    assign attNoise          = att_noise_q;
    assign noiseFeedbackType = nfb_q;
    assign noiseFeed         = nfeed_q;
    assign noiseReset        = noise_reset_q;
`ifdef GG_STEREO_EN
    assign stereo            = stereo_q;
`endif

endmodule

// File: doc/sn76489_psg_bus_interface.md
# sn76489_psg_bus_interface

Parametrised CPU write interface for the SN76489-compatible PSG in the 315-5124 VDP. It decodes genuine latch/data byte pairs, holds a configurable write-wait window, and exports packed per-channel tone, attenuation and noise registers to the tone generators. It sits between the Z80 port decode (nCE/nWE) and the PSG synthesis blocks. It adds an optional Game Gear stereo register.

## Interface
Parameters:
- NUM_TONE, 3: number of tone channels, 1..3; channel code 3 is always noise.
- WAIT_CYCLES, 32: clock cycles from write capture to register commit, >=1.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- nReset  in  1  asynchronous, active-low reset.
- d  in  8  CPU data bus.
- nWE  in  1  write strobe, active low.
- nCE  in  1  PSG chip enable, active low.
- ready  out  1  high when a new write is accepted; low during the wait window.
- freq  out  NUM_TONE*10  tone periods; channel c at bits [c*10+9:c*10].
- att  out  NUM_TONE*4  tone attenuations; channel c at bits [c*4+3:c*4].
- attNoise  out  4  noise attenuation.
- noiseFeedbackType  out  1  1 = white noise, 0 = periodic.
- noiseFeed  out  2  noise shift-rate select.
- noiseReset  out  1  one-cycle pulse on every noise-control commit.
- nStereoCE  in  1  stereo register enable, active low (GG_STEREO_EN only).
- stereo  out  8  Game Gear stereo mask (GG_STEREO_EN only).

## Operation
- Reset values: freq 0, att all 4'hF, attNoise 4'hF, noiseFeedbackType 0, noiseFeed 0, noiseReset 0, stereo 8'hFF, ready 1, state IDLE, latched register = channel 0 tone.
- States:
  - IDLE: on a clock edge sampling nCE=0 and nWE=0: capture d, load counter with WAIT_CYCLES-1, go to BUSY.
  - BUSY: counter decrements each cycle. At counter==0: commit the captured byte and go to FINISH.
  - FINISH: stay until nCE=1 and nWE=1 are sampled, then go to IDLE. This gives one commit per strobe.
- ready = (state==IDLE) || (state==FINISH).
- Latch byte (d[7]=1): c=d[6:5], t=d[4]. The latched register becomes {c,t} regardless of validity.
  - c<NUM_TONE, t=0: freq[c][3:0] <= d[3:0].
  - c<NUM_TONE, t=1: att[c] <= d[3:0].
  - c=3, t=0: noiseFeedbackType <= d[2], noiseFeed <= d[1:0], pulse noiseReset.
  - c=3, t=1: attNoise <= d[3:0].
  - NUM_TONE<=c<3: no register change.
- Data byte (d[7]=0) acts on the latched register:
  - Tone: freq[c][9:4] <= d[5:0].
  - Attenuation: att or attNoise <= d[3:0].
  - Noise control: same as the latch form, including the noiseReset pulse.
  - Invalid channel: ignored.
- Data bytes may repeat without a new latch. Each one re-targets the same register.
- Bits outside the written field are preserved.

## Timing
- Capture edge E0 is the first edge with nCE=0 and nWE=0 in IDLE. ready falls after E0.
- Commit at edge E0+WAIT_CYCLES: outputs update and the state enters FINISH. ready rises after that edge.
- noiseReset is high for exactly the cycle after the commit edge.
- nCE or nWE deasserted during BUSY does not abort the write. If both are high when the commit completes, FINISH exits on the next edge.
- d is sampled only at E0; later bus changes are ignored.
- nReset low at any time immediately forces reset values and drops any in-flight write. Recovery is synchronous to the first clock edge after nReset rises.

## Configuration
- GG_STEREO_EN defined:
  - nStereoCE and stereo exist.
  - In IDLE, nStereoCE=0 with nWE=0 follows the same BUSY/FINISH sequence and commits stereo <= d.
  - FINISH also requires nStereoCE=1 to exit.
  - If nCE and nStereoCE are both low at E0, the PSG write wins and the stereo write is dropped.
- GG_STEREO_EN undefined: nStereoCE and stereo are absent, and no stereo logic is present.

## Test plan
- Reset, then idle: att=16'hFFF, attNoise=F, freq=0, ready=1; noiseReset never pulses.
- Write 8'h8E, then 8'h3F on channel 0 tone (WAIT_CYCLES=32):
  - ready stays low 32 cycles per byte.
  - After the first commit, freq[9:0]=10'h00E; after the second, 10'h3FE.
- Write 8'hB5, then 8'h0A (channel 1 attenuation, then data byte): att[7:4]=5, then A; att[0] and att[2] remain F.
- Write 8'hE5 (noise control): noiseFeedbackType=1, noiseFeed=2'b01, one-cycle noiseReset pulse; then write 8'hFC: attNoise=C.
- NUM_TONE=2, write 8'hC7 then 8'h12: no output changes. Assert nReset mid-BUSY: outputs return to reset values, ready=1, and no commit occurs.
- GG_STEREO_EN, write 8'h5A via nStereoCE: stereo=8'h5A after WAIT_CYCLES. With nCE and nStereoCE both low, d=8'h90: att[3:0]=0 and stereo is unchanged.
